// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin owner of the shared 4:1 mux: picks a requester, drives sel, forwards its word.
// Latency: req to grant 1 cycle; grant to transfer 0 cycles when out_ready is high.
// Backpressure: out_valid & !out_ready freezes grant/sel/ptr; optional burst lock via MUX_ARB_LOCK_EN.
module mux_4x1_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req,
    input  logic [3:0]           lock,
    input  logic [4*WIDTH-1:0]   data_in,
    input  logic                 out_ready,
    output logic [3:0]           grant,
    output logic [1:0]           sel,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic                 busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  ptr_q, ptr_d;
    logic        xfer;
    logic        hold;
    logic        found;

`ifdef MUX_ARB_LOCK_EN
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign hold = lock[sel_q] & req[sel_q] & (cnt_q < HOLD_LAST);
`else
    logic unused_lock;

    assign unused_lock = ^lock;
    assign hold        = 1'b0;
`endif

    assign busy      = (state_q == GRANT);
    assign out_valid = busy & req[sel_q];
    assign xfer      = out_valid & out_ready;
    assign grant     = grant_q;
    assign sel       = sel_q;
    assign out_data  = data_in[sel_q*WIDTH +: WIDTH];

    always_comb begin
        logic [1:0] idx;
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 2'd0;
`ifdef MUX_ARB_LOCK_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef MUX_ARB_LOCK_EN
                cnt_d = '0;
`endif
                // Search starts at ptr so the last-served requester goes to the back
                for (int k = 0; k < 4; k++) begin
                    idx = ptr_q + 2'(k);
                    if (!found && req[idx]) begin
                        found   = 1'b1;
                        sel_d   = idx;
                        grant_d = 4'b0001 << idx;
                        state_d = GRANT;
                    end
                end
            end
            GRANT: begin
                if (xfer) begin
                    if (hold) begin
`ifdef MUX_ARB_LOCK_EN
                        cnt_d = cnt_q + 1'b1;
`endif
                    end else begin
                        ptr_d   = sel_q + 2'd1;
                        grant_d = 4'b0000;
                        state_d = IDLE;
`ifdef MUX_ARB_LOCK_EN
                        cnt_d   = '0;
`endif
                    end
                end else if (!req[sel_q]) begin
                    // Requester withdrew: give up the slot without advancing ptr
                    grant_d = 4'b0000;
                    state_d = IDLE;
`ifdef MUX_ARB_LOCK_EN
                    cnt_d   = '0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef MUX_ARB_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// Bench for mux_4x1_rr_arbiter: expected beats queued at stimulus time, popped on each observed transfer.
module tb_mux_4x1_rr_arbiter;

    localparam int WIDTH = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [3:0]          req;
    logic [3:0]          lock;
    logic [4*WIDTH-1:0]  data_in;
    logic                out_ready;
    logic [3:0]          grant;
    logic [1:0]          sel;
    logic                out_valid;
    logic [WIDTH-1:0]    out_data;
    logic                busy;

    int total = 0;
    int bad   = 0;
    logic [9:0] exp_q[$];

    mux_4x1_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .data_in   (data_in),
        .out_ready (out_ready),
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] word(input int i);
        return data_in[i*WIDTH +: WIDTH];
    endfunction

    task automatic push(input int i);
        exp_q.push_back({2'(i), word(i)});
    endtask

    task automatic check_grant(input string tag, input int i);
        chk({tag, "_grant"}, grant, 32'(4'b0001 << i));
        chk({tag, "_sel"}, sel, i);
        chk({tag, "_busy"}, busy, 1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, out_valid, 0);
    endtask

    // Scoreboard side: every accepted beat must match the next queued requester/word
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_beat", 1, 0);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                chk("sb_sel", sel, e[9:8]);
                chk("sb_data", out_data, e[7:0]);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        req       = 4'b0000;
        lock      = 4'b0000;
        out_ready = 1'b0;
        data_in   = {8'h3C, 8'hA5, 8'h5A, 8'h11};

        // Reset state
        tick();
        tick();
        check_idle("rst");
        chk("rst_sel", sel, 0);
        chk("rst_data", out_data, 8'h11);
        rst_n = 1'b1;
        tick();
        check_idle("rst_rel");

        // Single request, ptr moves to 3
        req = 4'b0100; out_ready = 1'b1; push(2);
        tick();
        check_grant("single", 2);
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 8'hA5);
        tick();
        req = 4'b0000;
        check_idle("single_rel");
        chk("single_sel_hold", sel, 2);

        // ptr=3 => requester 3 beats requester 0, then 0
        req = 4'b1001; push(3);
        tick();
        check_grant("ptr3", 3);
        tick();
        req = 4'b0001; push(0);
        tick();
        check_grant("ptr3_next", 0);
        tick();
        req = 4'b0000;

        // Asynchronous reset between edges while granted
        req = 4'b0100; out_ready = 1'b0;
        tick();
        check_grant("midrst_pre", 2);
        #2 rst_n = 1'b0;
        #1;
        check_idle("midrst");
        chk("midrst_sel", sel, 0);
        chk("midrst_data", out_data, 8'h11);
        req = 4'b0000;
        tick();
        rst_n = 1'b1;

        // Fairness from ptr=0 with all requesting
        req = 4'b1111; out_ready = 1'b1;
        for (int n = 0; n < 5; n++) push(n % 4);
        for (int n = 0; n < 5; n++) begin
            tick();
            check_grant($sformatf("fair%0d", n), n % 4);
            tick();
            if (n == 4) req = 4'b0000;
            check_idle($sformatf("fair%0d_gap", n));
        end

        // Backpressure: ptr=1, requester 1 held for 3 stalled cycles
        req = 4'b0010; out_ready = 1'b0;
        tick();
        for (int n = 0; n < 3; n++) begin
            check_grant($sformatf("bp%0d", n), 1);
            chk($sformatf("bp%0d_valid", n), out_valid, 1);
            tick();
        end
        out_ready = 1'b1; push(1);
        check_grant("bp_go", 1);
        tick();
        req = 4'b0000;
        check_idle("bp_rel");

        // Abandon: ptr=2, requester 3 withdraws, ptr must stay at 2
        req = 4'b1000; out_ready = 1'b0;
        tick();
        check_grant("abn", 3);
        req = 4'b0000;
        tick();
        check_idle("abn_idle");
        req = 4'b1001; out_ready = 1'b1; push(3);
        tick();
        check_grant("abn_again", 3);
        tick();
        req = 4'b0000;

        // Move ptr to 1 for the lock scenario
        req = 4'b0001; push(0);
        tick();
        tick();
        req = 4'b0000;
        tick();

        req = 4'b0011; lock = 4'b0010; out_ready = 1'b1;
`ifdef MUX_ARB_LOCK_EN
        for (int n = 0; n < 4; n++) push(1);
        push(0);
        for (int n = 0; n < 4; n++) begin
            tick();
            check_grant($sformatf("lock_beat%0d", n), 1);
        end
`else
        push(1);
        push(0);
        tick();
        check_grant("nolock_beat", 1);
`endif
        tick();
        req = 4'b0001; lock = 4'b0000;
        check_idle("lock_rel");
        tick();
        check_grant("lock_next", 0);
        tick();
        req = 4'b0000;
        tick();
        tick();
        check_idle("end");
        chk("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
